// File: rtl/divider4.sv
// Sequential signed divider: truncated quotient and remainder from N-bit two's-complement operands.
// Latency: fixed N+1 clock edges from the accepting edge; outputs update on the FIX->IDLE edge.
// Backpressure: none; start is accepted only while ready=1, and a start seen while busy is dropped.
module divider4 #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         ready,
  output logic         div_by_zero
);

  // Iteration counter only needs to reach N-1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // dvd starts as |A| and is progressively replaced by quotient bits from the LSB.
  logic [N-1:0]  dvd;
  logic [N:0]    rem;
  logic [N-1:0]  bmag;
  logic          sign_q;
  logic          sign_r;
  logic          zero_b;

  // Operand magnitudes; |-2^(N-1)| = 2^(N-1) is representable as N-bit unsigned.
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;

  // One restoring-division step.
  logic [N+1:0]  rem_sh;
  logic [N+1:0]  trial;
  logic          q_bit;
  logic [N:0]    rem_nx;
  logic [N-1:0]  dvd_nx;

  // Sign-corrected results produced in FIX.
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  assign ready = (state == S_IDLE);

  // Absolute values of the incoming operands.
  always_comb begin
    a_mag = A;
    b_mag = B;
    if (A[N-1]) a_mag = ~A + ONE_N;
    if (B[N-1]) b_mag = ~B + ONE_N;
  end

  // Shift {rem, dvd} left, trial-subtract the divisor, keep or restore.
  // The shifted remainder is below 2^N and the divisor at most 2^(N-1),
  // so an N+2-bit difference carries a reliable sign bit.
  always_comb begin
    rem_sh = {rem, dvd[N-1]};
    trial  = rem_sh - {2'b00, bmag};
    q_bit  = ~trial[N+1];
    rem_nx = rem_sh[N:0];
    if (q_bit) rem_nx = trial[N:0];
    dvd_nx = {dvd[N-2:0], q_bit};
  end

  // Apply signs: quotient negative when operand signs differ, remainder follows the dividend.
  // A zero divisor forces the quotient to all ones; the remainder naturally comes out as A.
  always_comb begin
    q_fix = dvd;
    if (sign_q) q_fix = ~dvd + ONE_N;
    if (zero_b) q_fix = '1;
    r_fix = rem[N-1:0];
    if (sign_r) r_fix = ~rem[N-1:0] + ONE_N;
  end

  // Control FSM, iteration counter and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dvd         <= '0;
      rem         <= '0;
      bmag        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_b      <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd    <= a_mag;
            bmag   <= b_mag;
            rem    <= '0;
            sign_q <= A[N-1] ^ B[N-1];
            sign_r <= A[N-1];
            zero_b <= (B == '0);
            cnt    <= CNT_LAST;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          dvd <= dvd_nx;
          rem <= rem_nx;
          cnt <= cnt - ONE_C;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          Quotient    <= q_fix;
          Remainder   <= r_fix;
          div_by_zero <= zero_b;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider4.sv
// Self-checking bench for divider4: directed cases, busy/reset corner cases and random operands.
// Expected results come from a signed-division model pushed to a scoreboard at start time.
// Latency and hold-during-busy behaviour are checked every cycle of every operation.
module tb_divider4;

  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         ready;
  logic         div_by_zero;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [N-1:0] last_q  = '0;
  logic [N-1:0] last_r  = '0;
  logic         last_dz = 1'b0;

  always #5 clk = ~clk;

  divider4 #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .ready       (ready),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: truncating signed division; zero divisor gives -1 and the dividend.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   ia;
    int   ib;
    int   iq;
    int   ir;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      ia   = signed'(a);
      ib   = signed'(b);
      iq   = ia / ib;
      ir   = ia % ib;
      e.q  = iq[N-1:0];
      e.r  = ir[N-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Present operands for one accepting edge, then drive them to X.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 'x;
    B     = 'x;
    check("ready_fall", 32'(ready), 32'd0);
    if (push) sb.push_back(model(a, b));
  endtask

  // Wait (bounded) for ready; optionally pulse a stray start just before edge poke_edge.
  task automatic wait_result(input int poke_edge);
    int   edges;
    bit   done;
    exp_t e;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < N + 6) begin
      if (edges + 1 == poke_edge) begin
        @(negedge clk);
        start = 1'b1;
        A     = 12'd9;
        B     = 12'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = 'x;
      B     = 'x;
      edges++;
      if (ready) begin
        done = 1'b1;
      end else begin
        check("hold_q", 32'(Quotient), 32'(last_q));
        check("hold_dz", 32'(div_by_zero), 32'(last_dz));
      end
    end
    check("latency", 32'(edges), 32'(N + 1));
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("quotient", 32'(Quotient), 32'(e.q));
      check("remainder", 32'(Remainder), 32'(e.r));
      check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      last_q  = e.q;
      last_r  = e.r;
      last_dz = e.dz;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [N-1:0] a;
    logic [N-1:0] b;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_q", 32'(Quotient), 32'd0);
    check("rst_r", 32'(Remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // Sign combinations and boundary operands.
    start_op(12'd100, 12'd7, 1'b1);      wait_result(0);
    start_op(-12'sd100, 12'd7, 1'b1);    wait_result(0);
    start_op(12'd100, -12'sd7, 1'b1);    wait_result(0);
    start_op(-12'sd2048, -12'sd1, 1'b1); wait_result(0);
    start_op(-12'sd2048, 12'd1, 1'b1);   wait_result(0);
    start_op(12'd2047, 12'd2047, 1'b1);  wait_result(0);

    // Divide by zero, then a normal division clears the flag.
    start_op(12'd37, 12'd0, 1'b1);       wait_result(0);
    start_op(-12'sd37, 12'd0, 1'b1);     wait_result(0);
    start_op(12'd50, 12'd5, 1'b1);       wait_result(0);

    // Stray start while busy is dropped; so is one coincident with the FIX edge.
    start_op(12'd100, 12'd7, 1'b1);      wait_result(5);
    start_op(12'd9, 12'd3, 1'b1);        wait_result(N + 1);
    @(posedge clk);
    #1;
    check("no_restart", 32'(ready), 32'd1);

    // Reset at edge 6 of a division, with a start on the same edge.
    start_op(12'd100, 12'd7, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst   = 1'b1;
    start = 1'b1;
    A     = 12'd50;
    B     = 12'd5;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_q", 32'(Quotient), 32'd0);
    check("abort_r", 32'(Remainder), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    check("abort_idle", 32'(ready), 32'd1);
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    start_op(-12'sd1500, 12'd13, 1'b1);  wait_result(0);

    // Random operands with nonzero divisor.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      a  = ra[N-1:0];
      b  = rb[N-1:0];
      if (b == '0) b = 12'd1;
      start_op(a, b, 1'b1);
      wait_result(0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
